// File: rtl/uart_tx_frame_ctrl.sv
// Frame sequencer and serializer feeding the UART TX output mux.
// One bit per CLK. Outputs are registered from the next-state decode.
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy,
    output logic                  ready
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                nxt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CW-1:0]         cnt_q;
    logic                  par_en_q;
    logic                  accept;
    logic                  last_bit;

    assign accept   = Data_Valid & ready;
    assign last_bit = (cnt_q == CW'(DATA_WIDTH - 1));
    assign ser_data = shift_q[0];

    function automatic logic [1:0] sel_of(input state_t s);
        logic [1:0] sel;
        unique case (s)
            START:   sel = 2'b00;
            DATA:    sel = 2'b10;
            PARITY:  sel = 2'b11;
            default: sel = 2'b01;
        endcase
        return sel;
    endfunction

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (accept) nxt = START;
            START:   nxt = DATA;
            DATA: begin
                if (last_bit)
                    nxt = par_en_q ? PARITY : STOP;
            end
            PARITY:  nxt = STOP;
            STOP:    nxt = accept ? START : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Status outputs track the state being entered, so they flip with it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            mux_sel  <= 2'b01;
            busy     <= 1'b0;
            ready    <= 1'b1;
            shift_q  <= '0;
            cnt_q    <= '0;
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            state   <= nxt;
            mux_sel <= sel_of(nxt);
            busy    <= (nxt != IDLE);
            ready   <= (nxt == IDLE) || (nxt == STOP);
            if (accept) begin
                shift_q  <= P_DATA;
                cnt_q    <= '0;
                par_en_q <= PAR_EN;
                par_bit  <= PAR_TYP ? ~^P_DATA : ^P_DATA;
            end else if (state == DATA) begin
                shift_q <= shift_q >> 1;
                cnt_q   <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: per-cycle comparison against a
// symbol-queue model of the UART frame.
module tb_uart_tx_frame_ctrl;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [1:0]    mux_sel;
    logic          ser_data;
    logic          par_bit;
    logic          busy;
    logic          ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // kind: 0 idle, 1 start, 2 data, 3 parity, 4 stop
    typedef struct packed {
        logic [2:0] kind;
        logic       b;
    } sym_t;

    sym_t q[$];
    int   m_kind = 0;
    logic m_bit  = 1'b0;
    logic m_par  = 1'b0;

    uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK),
        .RST(RST),
        .P_DATA(P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .mux_sel(mux_sel),
        .ser_data(ser_data),
        .par_bit(par_bit),
        .busy(busy),
        .ready(ready)
    );

    always #5 CLK = ~CLK;

    function automatic logic [1:0] sel_of(input int k);
        case (k)
            1:       return 2'b00;
            2:       return 2'b10;
            3:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic [5:0] exp_vec();
        return {sel_of(m_kind), m_kind != 0,
                (m_kind == 0) || (m_kind == 4), m_par,
                (m_kind == 2) ? m_bit : 1'b0};
    endfunction

    function automatic logic [5:0] dut_vec();
        return {mux_sel, busy, ready, par_bit,
                (m_kind == 2) ? ser_data : 1'b0};
    endfunction

    task automatic model_reset();
        q.delete();
        m_kind = 0;
        m_bit  = 1'b0;
        m_par  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance model at the edge, return at negedge.
    task automatic tick(input logic dv, input logic [DW-1:0] d,
                        input logic pen, input logic ptyp);
        sym_t s;
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        @(posedge CLK);
        if (dv && (m_kind == 0 || m_kind == 4)) begin
            q.delete();
            q.push_back('{kind: 3'd1, b: 1'b0});
            for (int i = 0; i < DW; i++)
                q.push_back('{kind: 3'd2, b: d[i]});
            if (pen)
                q.push_back('{kind: 3'd3, b: 1'b0});
            q.push_back('{kind: 3'd4, b: 1'b0});
            m_par = (($countones(d) % 2) == 1) ^ ptyp;
        end
        if (q.size() > 0) begin
            s      = q.pop_front();
            m_kind = int'(s.kind);
            m_bit  = s.b;
        end else begin
            m_kind = 0;
            m_bit  = 1'b0;
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST        = 1'b0;
        Data_Valid = 1'b0;
        P_DATA     = '0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_state: got %b want %b",
                     dut_vec(), exp_vec());
        end
        checks++;
        if (ser_data !== 1'b0) begin
            errors++;
            $display("FAIL reset_ser_data: got %b want 0", ser_data);
        end
        RST = 1'b1;
        repeat (3) begin
            tick(1'b0, DW'($urandom), 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %b want %b",
                         cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_data();
        logic [5:0] rst_v;
        rst_v = 6'b01_0_1_0_0;
        tick(1'b1, 8'hFF, 1'b1, 1'b0);
        repeat (4) begin
            tick(1'b0, DW'($urandom), 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mid_rst_pre cyc %0d: got %b want %b",
                         cyc, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (!(m_kind == 2 && ser_data === 1'b1)) begin
            errors++;
            $display("FAIL mid_rst_bit3: got ser_data %b want 1",
                     ser_data);
        end
        RST = 1'b0;
        #1;
        checks++;
        if ({mux_sel, busy, ready, par_bit, ser_data} !== rst_v) begin
            errors++;
            $display("FAIL mid_rst_async: got %b want %b",
                     {mux_sel, busy, ready, par_bit, ser_data}, rst_v);
        end
        @(negedge CLK);
        checks++;
        if ({mux_sel, busy, ready, par_bit, ser_data} !== rst_v) begin
            errors++;
            $display("FAIL mid_rst_hold: got %b want %b",
                     {mux_sel, busy, ready, par_bit, ser_data}, rst_v);
        end
        RST = 1'b1;
        model_reset();
        repeat (12) begin
            tick(1'b0, DW'($urandom), 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec() || ser_data !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst_after cyc %0d: got %b/%b want %b/0",
                         cyc, dut_vec(), ser_data, exp_vec());
            end
        end
    endtask

    task automatic test_frame(input string name, input logic [DW-1:0] d,
                              input logic pen, input logic ptyp);
        int busy_n;
        int par_seen;
        busy_n   = 0;
        par_seen = 0;
        tick(1'b1, d, pen, ptyp);
        for (int c = 0; c < DW + 6; c++) begin
            if (busy === 1'b1) busy_n++;
            if (mux_sel === 2'b11) par_seen++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL %s cyc %0d: got %b want %b",
                         name, cyc, dut_vec(), exp_vec());
            end
            tick(1'b0, DW'($urandom), ~pen, ~ptyp);
        end
        checks++;
        if (busy_n != 2 + DW + int'(pen)) begin
            errors++;
            $display("FAIL %s_len: got %0d want %0d",
                     name, busy_n, 2 + DW + int'(pen));
        end
        checks++;
        if (par_seen != int'(pen)) begin
            errors++;
            $display("FAIL %s_par_cycles: got %0d want %0d",
                     name, par_seen, int'(pen));
        end
    endtask

    task automatic test_back_to_back();
        int       frames;
        int       busy_n;
        logic     dv;
        logic     pt;
        logic [DW-1:0] d;
        frames = 0;
        busy_n = 0;
        pt     = 1'($urandom);
        for (int c = 0; c < 30; c++) begin
            dv = (frames < 2);
            if (m_kind == 0 && frames == 0)      d = 8'h11;
            else if (m_kind == 4 && frames == 1) d = 8'h22;
            else                                 d = 8'hC3;
            if (dv && (m_kind == 0 || m_kind == 4)) frames++;
            tick(dv, d, 1'b1, pt);
            if (busy === 1'b1) busy_n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b cyc %0d: got %b want %b",
                         cyc, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (busy_n != 2 * (3 + DW)) begin
            errors++;
            $display("FAIL b2b_busy: got %0d want %0d",
                     busy_n, 2 * (3 + DW));
        end
    endtask

    task automatic test_ignore_valid();
        int starts;
        logic dv;
        starts = 0;
        tick(1'b1, DW'($urandom), 1'b1, 1'($urandom));
        for (int c = 0; c < DW + 8; c++) begin
            if (mux_sel === 2'b00) starts++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ignore_dv cyc %0d: got %b want %b",
                         cyc, dut_vec(), exp_vec());
            end
            dv = (m_kind >= 1 && m_kind <= 3);
            tick(dv, DW'($urandom), 1'($urandom), 1'($urandom));
        end
        checks++;
        if (starts != 1) begin
            errors++;
            $display("FAIL ignore_dv_starts: got %0d want 1", starts);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            tick(($urandom % 3) == 0, DW'($urandom),
                 1'($urandom), 1'($urandom));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %b want %b",
                         cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_data();
        test_frame("even_a5", 8'hA5, 1'b1, 1'b0);
        test_frame("odd_01", 8'h01, 1'b1, 1'b1);
        test_frame("even_01", 8'h01, 1'b1, 1'b0);
        test_frame("nopar_3c", 8'h3C, 1'b0, 1'b0);
        test_back_to_back();
        test_ignore_valid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
